// File: rtl/sonar_pkg.sv
// Shared types and defaults for the sonar ping sequencer.
// Holds the FSM state enum, default widths, DIV_MIN and a phase helper.
package sonar_pkg;

  localparam int DIV_W   = 8;
  localparam int CNT_W   = 16;
  localparam int TX_W    = 8;
  localparam int DIV_MIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    BLANK,
    LISTEN,
    DONE
  } state_t;

  // First phase of a ping that actually has work in it.
  function automatic state_t first_phase(
    input logic tx_zero,
    input logic blank_zero
  );
    if (!tx_zero) return TX;
    if (!blank_zero) return BLANK;
    return LISTEN;
  endfunction

endpackage

// File: rtl/sonar_tick_gen.sv
// Sample-rate divider: counts 0..div_c-1 while en, tick on the last count.
// Ports: clk, rst (sync, high), clr, en, div_c -> tick.
module sonar_tick_gen #(
  parameter int DIV_W = sonar_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_c,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             at_end;

  assign at_end = (count == div_c - DIV_W'(1));
  assign tick   = en && at_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// Sequences one sonar ping: TX burst, blanking, then a strobed listen window.
// Ports: start/abort/config in; tx_out, sample_en, sample_idx, busy, done,
// cfg_err out. Macro SONAR_SEQ_REARM_EN adds the cont re-arm input.
module sonar_ping_sequencer #(
  parameter int DIV_W = sonar_pkg::DIV_W,
  parameter int CNT_W = sonar_pkg::CNT_W,
  parameter int TX_W  = sonar_pkg::TX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef SONAR_SEQ_REARM_EN
  input  logic             cont,
`endif
  input  logic [DIV_W-1:0] div_c,
  input  logic [TX_W-1:0]  tx_cycles,
  input  logic [CNT_W-1:0] blank_samples,
  input  logic [CNT_W-1:0] listen_samples,
  output logic             tx_out,
  output logic             sample_en,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  import sonar_pkg::*;

  localparam logic [DIV_W-1:0] DMIN = DIV_W'(DIV_MIN);

  state_t state, state_n;

  logic [DIV_W-1:0] div_q;
  logic [TX_W-1:0]  tx_q;
  logic [CNT_W-1:0] blank_q;
  logic [CNT_W-1:0] listen_q;

  logic [TX_W:0]    tx_cnt;
  logic [CNT_W-1:0] blank_cnt;

  logic [TX_W:0]    tx_last;
  logic [CNT_W-1:0] blank_last;
  logic [CNT_W-1:0] listen_last;

  logic tick;
  logic cfg_ok;
  logic accept;
  logic entry;

  assign cfg_ok = (div_c >= DMIN) && (listen_samples != '0);
  assign accept = (state == IDLE) && start && cfg_ok;
  assign entry  = (state_n != state);

  // TX ends on the tick that completes 2*tx_cycles half-periods.
  assign tx_last     = {tx_q, 1'b0} - (TX_W + 1)'(1);
  assign blank_last  = blank_q - CNT_W'(1);
  assign listen_last = listen_q - CNT_W'(1);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sample_en = (state == LISTEN) && tick;

  // Divider restarts on every phase change so ticks align to phase entry.
  sonar_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (entry),
    .en    (busy),
    .div_c (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = first_phase(tx_cycles == '0,
                                blank_samples == '0);
        end
      end
      TX: begin
        if (tick && tx_cnt == tx_last) begin
          state_n = (blank_q == '0) ? LISTEN : BLANK;
        end
      end
      BLANK: begin
        if (tick && blank_cnt == blank_last) begin
          state_n = LISTEN;
        end
      end
      LISTEN: begin
        if (tick && sample_idx == listen_last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
`ifdef SONAR_SEQ_REARM_EN
        if (cont) begin
          state_n = first_phase(tx_q == '0, blank_q == '0);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_q      <= '0;
      tx_q       <= '0;
      blank_q    <= '0;
      listen_q   <= '0;
      tx_cnt     <= '0;
      blank_cnt  <= '0;
      sample_idx <= '0;
      tx_out     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (accept) begin
        div_q    <= div_c;
        tx_q     <= tx_cycles;
        blank_q  <= blank_samples;
        listen_q <= listen_samples;
      end
      if (state == LISTEN && tick) begin
        sample_idx <= sample_idx + CNT_W'(1);
      end
      if (entry) begin
        tx_cnt    <= '0;
        blank_cnt <= '0;
        tx_out    <= (state_n == TX);
        // Index survives into DONE; any other phase change restarts it.
        if (state_n != DONE) begin
          sample_idx <= '0;
        end
      end else if (tick) begin
        if (state == TX) begin
          tx_cnt <= tx_cnt + (TX_W + 1)'(1);
          tx_out <= ~tx_out;
        end
        if (state == BLANK) begin
          blank_cnt <= blank_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Self-checking bench for sonar_ping_sequencer.
// Strobe events are scoreboarded; other outputs are checked per cycle.
module tb_sonar_ping_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
`ifdef SONAR_SEQ_REARM_EN
  logic        cont;
`endif
  logic [7:0]  div_c;
  logic [7:0]  tx_cycles;
  logic [15:0] blank_samples;
  logic [15:0] listen_samples;
  logic        tx_out;
  logic        sample_en;
  logic [15:0] sample_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  sonar_ping_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
`ifdef SONAR_SEQ_REARM_EN
    .cont           (cont),
`endif
    .div_c          (div_c),
    .tx_cycles      (tx_cycles),
    .blank_samples  (blank_samples),
    .listen_samples (listen_samples),
    .tx_out         (tx_out),
    .sample_en      (sample_en),
    .sample_idx     (sample_idx),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  // Drives start through edge 0; returns at the negedge of cycle 1.
  task automatic launch(input int d, input int t, input int b, input int l);
    @(negedge clk);
    div_c          = 8'(d);
    tx_cycles      = 8'(t);
    blank_samples  = 16'(b);
    listen_samples = 16'(l);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_ping(input int d, input int t, input int b, input int l);
    int done_cyc;
    logic exp_tx;
    ev_t e;
    done_cyc = 2*t*d + b*d + l*d + 1;
    for (int i = 0; i < l; i++) begin
      e.cyc = 2*t*d + b*d + (i + 1)*d;
      e.idx = i;
      sb.push_back(e);
    end
    launch(d, t, b, l);
    for (int k = 1; k <= done_cyc + 2; k++) begin
      exp_tx = (k <= 2*t*d) && (((k - 1) / d) % 2 == 0);
      total++;
      if (tx_out !== exp_tx) begin
        bad++;
        $display("FAIL tx_out cyc=%0d got=%b exp=%b", k, tx_out, exp_tx);
      end
      total++;
      if (done !== (k == done_cyc)) begin
        bad++;
        $display("FAIL done cyc=%0d got=%b exp=%b", k, done, k == done_cyc);
      end
      total++;
      if (busy !== (k <= done_cyc)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, k <= done_cyc);
      end
      if (sample_en === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL strobe_extra cyc=%0d got=1 exp=0", k);
        end else begin
          e = sb.pop_front();
          if (e.cyc != k || int'(sample_idx) != e.idx) begin
            bad++;
            $display("FAIL strobe cyc=%0d idx=%0d exp_cyc=%0d exp_idx=%0d",
                     k, sample_idx, e.cyc, e.idx);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL strobe_missing left=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_out, sample_en, busy, done, cfg_err} !== 5'b0
        || sample_idx !== 16'd0) begin
      bad++;
      $display("FAIL reset_outs got=%b idx=%0d exp=0",
               {tx_out, sample_en, busy, done, cfg_err}, sample_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_main;
    run_ping(4, 2, 3, 5);
    run_ping(2, 1, 1, 3);
    run_ping(int'($urandom_range(5, 2)), int'($urandom_range(3, 1)),
             int'($urandom_range(3, 0)), int'($urandom_range(4, 1)));
  endtask

  task automatic test_zero_phases;
    run_ping(3, 0, 0, 2);
    run_ping(2, 0, 2, 1);
  endtask

  task automatic test_cfg_err;
    int dv[3] = '{1, 0, 4};
    int lv[3] = '{5, 5, 0};
    for (int i = 0; i < 3; i++) begin
      launch(dv[i], 1, 1, lv[i]);
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_pulse case=%0d err=%b busy=%b exp=1,0",
                 i, cfg_err, busy);
      end
      @(negedge clk);
      total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_clear case=%0d err=%b busy=%b exp=0,0",
                 i, cfg_err, busy);
      end
    end
  endtask

  task automatic test_reset_mid_listen;
    launch(4, 2, 3, 5);
    repeat (33) @(negedge clk);
    total++;
    if (sample_idx !== 16'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset idx=%0d busy=%b exp=1,1", sample_idx, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({tx_out, sample_en, busy, done, cfg_err} !== 5'b0
        || sample_idx !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b idx=%0d exp=0",
               {tx_out, sample_en, busy, done, cfg_err}, sample_idx);
    end
    rst = 1'b0;
    run_ping(4, 2, 3, 5);
  endtask

  task automatic test_abort;
    logic seen_done;
    launch(4, 2, 3, 5);
    repeat (4) @(negedge clk);
    start          = 1'b1;
    div_c          = 8'd1;
    listen_samples = 16'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start err=%b busy=%b exp=0,1", cfg_err, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (tx_out !== 1'b1) begin
      bad++;
      $display("FAIL second_pulse tx_out=%b exp=1", tx_out);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (tx_out !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort tx_out=%b busy=%b exp=0,0", tx_out, busy);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet seen=%b exp=0", seen_done);
    end
    div_c          = 8'd2;
    listen_samples = 16'd1;
    start          = 1'b1;
    abort          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_wins busy=%b exp=1", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy busy=%b exp=0", busy);
    end
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort busy=%b err=%b exp=0,0", busy, cfg_err);
    end
  endtask

`ifdef SONAR_SEQ_REARM_EN
  task automatic test_rearm;
    logic exp_tx;
    cont = 1'b1;
    launch(2, 1, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      exp_tx = (k <= 2) || (k == 8);
      total++;
      if (tx_out !== exp_tx || done !== (k == 7) || busy !== 1'b1) begin
        bad++;
        $display("FAIL rearm cyc=%0d tx=%b done=%b busy=%b exp=%b,%b,1",
                 k, tx_out, done, busy, exp_tx, k == 7);
      end
      @(negedge clk);
    end
    cont  = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rearm_stop busy=%b exp=0", busy);
    end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
`ifdef SONAR_SEQ_REARM_EN
    cont           = 1'b0;
`endif
    div_c          = 8'd0;
    tx_cycles      = 8'd0;
    blank_samples  = 16'd0;
    listen_samples = 16'd0;
    test_reset();
    test_main();
    test_zero_phases();
    test_cfg_err();
    test_reset_mid_listen();
    test_abort();
`ifdef SONAR_SEQ_REARM_EN
    test_rearm();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
